acs_pm_unit: RTL
================

Name: acs_pm_unit

Overview:
- Add-compare-select and path-metric storage stage for the 4-state (K=3, rate-1/2, generators 7/5 octal) hard-decision Viterbi decoder.
- Sits directly downstream of the branch-metric computation stage. Consumes the four per-codeword Hamming branch metrics for each received pair.
- Updates and normalizes four path metrics and emits one survivor decision bit per state to the traceback stage.

Parameters:
- PM_W, 6, path metric width in bits (legal range 4..8).
- INIT_BIAS, 8, initial metric of states 1..3 at reset/start. Must be ≤ 2^PM_W-1-4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  frame start: reinitialize path metrics
- in_valid  input  1  branch metrics valid this cycle
- bm00  input  2  Hamming metric vs codeword {g0,g1}=00 (0..2)
- bm01  input  2  metric vs codeword 01
- bm10  input  2  metric vs codeword 10
- bm11  input  2  metric vs codeword 11
- out_valid  output  1  one-cycle pulse: new decisions/metrics valid
- decision  output  4  bit n = survivor select for state n (0 = pred p0, 1 = pred p1)
- pm_flat  output  4*PM_W  path metrics, state n at bits [n*PM_W +: PM_W]
- best_state  output  2  state with minimum registered path metric
- step_cnt  output  16  accepted trellis steps since reset/start, wraps at 65535→0

Behaviour:
- One clock, synchronous active-high reset; all state updates on rising clk.
- Reset values:
  - pm = {0, INIT_BIAS, INIT_BIAS, INIT_BIAS} for states 0..3.
  - out_valid=0, decision=0, best_state=0, step_cnt=0.
- Trellis definitions:
  - State s = {u[t-1], u[t-2]}; next state ns = {u, s[1]}.
  - g0 = u^s1^s0, g1 = u^s0.
  - Predecessors of ns: p0 = {ns[0],0}, p1 = {ns[0],1}.
- Branch codewords, (p0 branch, p1 branch):
  - ns0: (00, 11)
  - ns1: (10, 01)
  - ns2: (11, 00)
  - ns3: (01, 10)
- Update when in_valid=1:
  - Candidate c0 = pm[p0] + bm(p0 branch); c1 = pm[p1] + bm(p1 branch). Computed in PM_W+1 bits.
  - Survivor = c1 if c1 < c0, else c0 (tie selects p0, decision bit 0).
  - m = min of the four survivors; new pm[n] = survivor[n] - m. Result saturates at 2^PM_W-1 (never reached with legal INIT_BIAS).
  - Registered: pm, decision, out_valid=1, step_cnt+1.
  - best_state = lowest index with new pm = 0.
- Latency: 1 cycle from in_valid to out_valid. No backpressure; a new step is accepted every cycle.
- When in_valid=0: pm, decision, best_state, step_cnt hold; out_valid=0.
- start=1, in_valid=0: pm ← reset pattern, step_cnt ← 0, decision ← 0, best_state ← 0, out_valid=0.
- start=1, in_valid=1: the add uses the reset pattern in place of the stored pm (the first step of the new frame). step_cnt ← 1, out_valid=1.
- rst overrides start and in_valid. Reset mid-frame discards all state, and out_valid=0 the next cycle.
- Branch-metric inputs above 2 are out of contract; no checking.

Test Plan:
- Reset → pm={0,8,8,8}, decision=0000, best_state=0, out_valid=0, step_cnt=0.
- All-zero channel (bm00=0, bm01=1, bm10=1, bm11=2) for 2 cycles:
  - Step 1 → pm={0,9,2,9}, decision=0000, best_state=0.
  - Step 2 → pm={0,3,2,3}, step_cnt=2.
- Encoded input 1,0,0 noiseless:
  - Step 1, (bm00,01,10,11)=(2,1,1,0) → pm={2,9,0,9}, best_state=2.
  - Step 2, (1,2,0,1) → pm={3,0,3,2}, best_state=1, decision=0000.
  - Step 3, (2,1,1,0) → pm={0,3,2,3}, decision=1111, best_state=0.
- in_valid low for 3 cycles mid-stream → pm, decision, step_cnt unchanged; out_valid=0 each cycle.
- start+in_valid with (0,1,1,2) after arbitrary history → pm={0,9,2,9}, step_cnt=1, out_valid=1.
- rst asserted during streaming → next cycle matches the reset values exactly. The following valid step behaves as the first step of a frame.

Source files
------------

// File: rtl/acs_pm_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : acs_pm_unit_if
//  Brief    : Branch-metric input and decision/path-metric output bundle for
//             the 4-state Viterbi add-compare-select stage.
//  Revision : 1.0  initial release
// ============================================================================
interface acs_pm_unit_if #(
    parameter int PM_W = 6
);
    logic                start;
    logic                in_valid;
    logic [1:0]          bm00;
    logic [1:0]          bm01;
    logic [1:0]          bm10;
    logic [1:0]          bm11;
    logic                out_valid;
    logic [3:0]          decision;
    logic [4*PM_W-1:0]   pm_flat;
    logic [1:0]          best_state;
    logic [15:0]         step_cnt;

    modport master (
        output start, in_valid, bm00, bm01, bm10, bm11,
        input  out_valid, decision, pm_flat, best_state, step_cnt
    );

    modport slave (
        input  start, in_valid, bm00, bm01, bm10, bm11,
        output out_valid, decision, pm_flat, best_state, step_cnt
    );
endinterface
`default_nettype wire

// File: rtl/acs_pm_unit.sv
`default_nettype none
// ============================================================================
//  Module   : acs_pm_unit
//  Brief    : Add-compare-select with normalized path-metric storage for the
//             K=3 (7,5) hard-decision Viterbi decoder; one step per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module acs_pm_unit #(
    parameter int PM_W      = 6,
    parameter int INIT_BIAS = 8
) (
    input  logic         clk,
    input  logic         rst,
    acs_pm_unit_if.slave bus
);
    localparam int                   c_W       = PM_W + 1;
    localparam logic [PM_W-1:0]      c_PM_MAX  = {PM_W{1'b1}};
    localparam logic [3:0][PM_W-1:0] c_PM_INIT = {{3{PM_W'(INIT_BIAS)}}, PM_W'(0)};

    logic [3:0][PM_W-1:0] r_pm;
    logic [3:0]           r_decision;
    logic [1:0]           r_best;
    logic [15:0]          r_step;
    logic                 r_out_valid;

    logic [c_W-1:0]       w_base [4];
    logic [1:0]           w_bm_p0 [4];
    logic [1:0]           w_bm_p1 [4];
    logic [c_W-1:0]       w_c0 [4];
    logic [c_W-1:0]       w_c1 [4];
    logic [c_W-1:0]       w_surv [4];
    logic [c_W-1:0]       w_diff [4];
    logic [3:0]           w_dec;
    logic [c_W-1:0]       w_min01;
    logic [c_W-1:0]       w_min23;
    logic [c_W-1:0]       w_min;
    logic [3:0][PM_W-1:0] w_pm_new;
    logic [1:0]           w_best;

    // Branch codewords entering each next state from (p0, p1)
    assign w_bm_p0[0] = bus.bm00;
    assign w_bm_p1[0] = bus.bm11;
    assign w_bm_p0[1] = bus.bm10;
    assign w_bm_p1[1] = bus.bm01;
    assign w_bm_p0[2] = bus.bm11;
    assign w_bm_p1[2] = bus.bm00;
    assign w_bm_p0[3] = bus.bm01;
    assign w_bm_p1[3] = bus.bm10;

    for (genvar n = 0; n < 4; n++) begin : g_acs
        localparam int c_P0 = 2 * (n % 2);
        localparam int c_P1 = c_P0 + 1;

        // A start coinciding with a valid step folds the frame's initial metrics in
        assign w_base[n]   = bus.start ? {1'b0, c_PM_INIT[n]} : {1'b0, r_pm[n]};
        assign w_c0[n]     = w_base[c_P0] + {{(c_W-2){1'b0}}, w_bm_p0[n]};
        assign w_c1[n]     = w_base[c_P1] + {{(c_W-2){1'b0}}, w_bm_p1[n]};
        assign w_dec[n]    = (w_c1[n] < w_c0[n]);
        assign w_surv[n]   = w_dec[n] ? w_c1[n] : w_c0[n];
        assign w_diff[n]   = w_surv[n] - w_min;
        assign w_pm_new[n] = w_diff[n][PM_W] ? c_PM_MAX : w_diff[n][PM_W-1:0];
    end

    assign w_min01 = (w_surv[1] < w_surv[0]) ? w_surv[1] : w_surv[0];
    assign w_min23 = (w_surv[3] < w_surv[2]) ? w_surv[3] : w_surv[2];
    assign w_min   = (w_min23 < w_min01) ? w_min23 : w_min01;

    always_comb begin
        w_best = 2'd3;
        if (w_pm_new[0] == '0) begin
            w_best = 2'd0;
        end else if (w_pm_new[1] == '0) begin
            w_best = 2'd1;
        end else if (w_pm_new[2] == '0) begin
            w_best = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pm        <= c_PM_INIT;
            r_decision  <= '0;
            r_best      <= '0;
            r_step      <= '0;
            r_out_valid <= 1'b0;
        end else if (bus.in_valid) begin
            r_pm        <= w_pm_new;
            r_decision  <= w_dec;
            r_best      <= w_best;
            r_step      <= bus.start ? 16'd1 : r_step + 16'd1;
            r_out_valid <= 1'b1;
        end else if (bus.start) begin
            r_pm        <= c_PM_INIT;
            r_decision  <= '0;
            r_best      <= '0;
            r_step      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.decision   = r_decision;
    assign bus.pm_flat    = r_pm;
    assign bus.best_state = r_best;
    assign bus.step_cnt   = r_step;
endmodule
`default_nettype wire
